rr_mux_arbiter_8: RTL and testbench

RR_MUX_ARBITER_8 -- requirements
Module: rr_mux_arbiter_8

---
 rtl/rr_mux_arbiter_8.sv | 118 +++++++++++
 tb/tb_rr_mux_arbiter_8.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter driving the select of a shared 8:1 mux; a requester may hold
// the path for at most MAX_HOLD consecutive cycles while others are waiting.
//
// state | meaning
// IDLE  | no grant, gnt/valid low, S and last hold their previous values
// GRANT | exactly one gnt bit set, S is its index, hold_cnt counts cycles held
module rr_mux_arbiter_8 #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] I,
   output logic [7:0] gnt,
   output logic [2:0] S,
   output logic       valid,
   output logic       Y
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [2:0] last, last_nxt;
   logic [2:0] s_nxt;
   logic [3:0] hold_cnt, hold_nxt;
   logic [7:0] gnt_nxt;
   logic       valid_nxt;
   logic [2:0] winner;
   logic [7:0] others;

   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
      logic [2:0] idx;
      logic       found;
      rr_pick = start;
      found   = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = start + 3'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // last always equals S while granting, so one search start serves every case
   assign winner = rr_pick(req, last + 3'd1);
   assign others = req & ~(8'b1 << S);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 8'd0;
         S        <= 3'd0;
         valid    <= 1'b0;
         hold_cnt <= 4'd0;
         last     <= 3'd7;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         S        <= s_nxt;
         valid    <= valid_nxt;
         hold_cnt <= hold_nxt;
         last     <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      s_nxt     = S;
      valid_nxt = valid;
      hold_nxt  = hold_cnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               s_nxt     = winner;
               last_nxt  = winner;
               gnt_nxt   = 8'b1 << winner;
               valid_nxt = 1'b1;
               hold_nxt  = 4'd1;
            end
         end
         GRANT: begin
            if (!req[S]) begin
               if (|req) begin
                  s_nxt     = winner;
                  last_nxt  = winner;
                  gnt_nxt   = 8'b1 << winner;
                  valid_nxt = 1'b1;
                  hold_nxt  = 4'd1;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 8'd0;
                  valid_nxt = 1'b0;
                  hold_nxt  = 4'd0;
               end
            end else if (hold_cnt < 4'(MAX_HOLD)) begin
               hold_nxt = hold_cnt + 4'd1;
            end else if (|others) begin
               s_nxt     = winner;
               last_nxt  = winner;
               gnt_nxt   = 8'b1 << winner;
               valid_nxt = 1'b1;
               hold_nxt  = 4'd1;
            end
            // sole requester at MAX_HOLD keeps the grant with hold_cnt saturated
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Y = valid ? I[S] : 1'b0;
   end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Bench for rr_mux_arbiter_8: directed scenarios plus randomized traffic, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_rr_mux_arbiter_8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'd0;
   logic [7:0] I   = 8'd0;
   logic [7:0] gnt;
   logic [2:0] S;
   logic       valid;
   logic       Y;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: cur = granted index or -1 when idle
   int m_cur  = -1;
   int m_last = 7;
   int m_hold = 0;
   int m_s    = 0;

   rr_mux_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .I    (I),
      .gnt  (gnt),
      .S    (S),
      .valid(valid),
      .Y    (Y)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int from);
      for (int k = 1; k <= 8; k++)
         if (r[(from + k) % 8]) return (from + k) % 8;
      return -1;
   endfunction

   function automatic int lowest(input logic [7:0] r);
      for (int k = 0; k < 8; k++)
         if (r[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_cur = -1; m_last = 7; m_hold = 0; m_s = 0;
   endtask

   task automatic model_grant(input logic [7:0] r);
      m_cur = pick(r, m_last); m_last = m_cur; m_s = m_cur; m_hold = 1;
   endtask

   task automatic model_step(input logic [7:0] r);
      if (m_cur < 0) begin
         if (r != 0) model_grant(r);
      end else if (!r[m_cur]) begin
         if (r != 0) model_grant(r);
         else begin m_cur = -1; m_hold = 0; end
      end else if (m_hold < MAX_HOLD) begin
         m_hold++;
      end else if ((r & ~(8'b1 << m_cur)) != 0) begin
         model_grant(r);
      end
   endtask

   task automatic check_outputs(input logic [7:0] d);
      logic [7:0] eg;
      logic       ey;
      eg = (m_cur < 0) ? 8'd0 : (8'b1 << m_cur);
      ey = (m_cur < 0) ? 1'b0 : d[m_cur];
      chk_val("gnt",   32'(gnt),   32'(eg));
      chk_val("S",     32'(S),     32'(m_s));
      chk_val("valid", 32'(valid), 32'(m_cur >= 0));
      chk_val("Y",     32'(Y),     32'(ey));
      chk_val("hold",  32'(dut.hold_cnt), 32'(m_hold));
   endtask

   // called just after a falling edge; leaves the bench just after the next one
   task automatic cycle(input logic [7:0] r, input logic [7:0] d);
      req = r;
      I   = d;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
      check_outputs(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk_val("rst_gnt",   32'(gnt),   32'd0);
      chk_val("rst_valid", 32'(valid), 32'd0);
      chk_val("rst_S",     32'(S),     32'd0);
      chk_val("rst_last",  32'(dut.last), 32'd7);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      int         w;
      repeat (2) @(negedge clk);
      chk_val("por_Y", 32'(Y), 32'd0);
      do_reset();

      // rotation across alternate requesters, wrap 7 -> 1
      for (int k = 0; k < 24; k++) cycle(8'hAA, 8'hAA);
      // lone requester keeps grant, hold saturates
      do_reset();
      for (int k = 0; k < 12; k++) cycle(8'h01, 8'h01);
      // release hands over without an idle bubble
      do_reset();
      cycle(8'h04, 8'h04);
      cycle(8'h44, 8'h00);
      cycle(8'h40, 8'h40);
      chk_val("handover_gnt", 32'(gnt), 32'h40);
      // wrap from 7 to 0 after hold expires, then idle
      do_reset();
      for (int k = 0; k < 6; k++) cycle(8'h80, 8'h80);
      cycle(8'h81, 8'h81);
      chk_val("wrap_S", 32'(S), 32'd0);
      cycle(8'h00, 8'hFF);

      // asynchronous reset between edges while granting
      cycle(8'hFF, 8'hFF);
      cycle(8'hFF, 8'hFF);
      @(posedge clk);
      model_step(req);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk_val("arst_gnt",   32'(gnt),   32'd0);
      chk_val("arst_valid", 32'(valid), 32'd0);
      chk_val("arst_Y",     32'(Y),     32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      cycle(8'hFF, 8'hFF);
      chk_val("arst_first_S", 32'(S), 32'd0);

      // every request pattern from a fresh reset grants the lowest set bit
      for (int p = 0; p < 256; p++) begin
         do_reset();
         r = 8'(p);
         cycle(r, 8'($urandom));
         w = lowest(r);
         if (w >= 0) chk_val("lowest_S", 32'(S), 32'(w));
         else        chk_val("zero_gnt", 32'(gnt), 32'd0);
      end

      // random traffic: requests tend to persist so holds and rotations occur
      do_reset();
      r = 8'($urandom);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(3, 0) == 0) r = 8'($urandom);
         if ($urandom_range(15, 0) == 0) r = 8'd0;
         if ($urandom_range(15, 0) == 0) r = 8'b1 << $urandom_range(7, 0);
         cycle(r, 8'($urandom));
         if (k % 500 == 499) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
